// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU codes, wide sequencer states and helpers
package alu_pkg;

    localparam int ALU_W  = 16;
    localparam int WIDE_W = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_OR    = 4'b0010,
        ALU_AND   = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_NOR   = 4'b0101,
        ALU_NAND  = 4'b0110,
        ALU_XNOR  = 4'b0111,
        ALU_SHL   = 4'b1000,
        ALU_SHR   = 4'b1001,
        ALU_ROL   = 4'b1010,
        ALU_ROR   = 4'b1011,
        ALU_NOT   = 4'b1100,
        ALU_RSV13 = 4'b1101,
        ALU_RSV14 = 4'b1110,
        ALU_RSV15 = 4'b1111
    } alu_sel_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        RESP = 2'd3
    } wide_state_e;

    // Shifts and rotates would need bits to cross the 16-bit word boundary,
    // which two independent ALU passes cannot provide.
    function automatic logic is_wide_supported(input logic [3:0] op);
        return (op <= 4'h7) || (op == 4'hC);
    endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// rtl/alu_wide_seq.sv - 32-bit operation sequencer over a 16-bit combinational ALU
//
// Runs each 32-bit op as two ALU passes (low word, then high word) with the
// carry chained through a flop. Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready/req_op/req_a/req_b/req_c_in   request channel
//   resp_valid/resp_ready/resp_result/resp_carry/resp_zero/resp_err  response
//   alu_enable/alu_sel/alu_a/alu_b/alu_c_in  -> external ALU
//   alu_out/alu_c_out                  <- external ALU
module alu_wide_seq
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [WIDE_W-1:0] req_a,
    input  logic [WIDE_W-1:0] req_b,
    input  logic              req_c_in,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WIDE_W-1:0] resp_result,
    output logic              resp_carry,
    output logic              resp_zero,
    output logic              resp_err,
    output logic              alu_enable,
    output logic [3:0]        alu_sel,
    output logic [ALU_W-1:0]  alu_a,
    output logic [ALU_W-1:0]  alu_b,
    output logic              alu_c_in,
    input  logic [ALU_W-1:0]  alu_out,
    input  logic              alu_c_out
);

    wide_state_e       state, state_nxt;
    logic [3:0]        op_q;
    logic [WIDE_W-1:0] a_q;
    logic [WIDE_W-1:0] b_q;
    logic              cin_q;
    logic              chain_q;
    logic [WIDE_W-1:0] result_q;
    logic              carry_q;
    logic              err_q;

    logic accept;
    logic op_add;
    logic op_sub;

    assign accept = req_valid && req_ready;
    assign op_add = (op_q == ALU_ADD);
    assign op_sub = (op_q == ALU_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            chain_q  <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= req_op;
                a_q      <= req_a;
                b_q      <= req_b;
                cin_q    <= req_c_in;
                result_q <= '0;
                carry_q  <= 1'b0;
                err_q    <= !is_wide_supported(req_op);
            end
            if (state == LO) begin
                result_q[ALU_W-1:0] <= alu_out;
                chain_q             <= alu_c_out;
            end
            if (state == HI) begin
                result_q[WIDE_W-1:ALU_W] <= alu_out;
                // SUB runs as a + ~b + ~borrow_in, so its carry is an inverted borrow
                carry_q <= op_add ? alu_c_out : (op_sub ? ~alu_c_out : 1'b0);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = is_wide_supported(req_op) ? LO : RESP;
                end
            end
            LO:   state_nxt = HI;
            HI:   state_nxt = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU drive is decoded from state and latched operands only, so the
    // combinational alu_out is valid within the same cycle.
    always_comb begin
        alu_enable = 1'b0;
        alu_sel    = '0;
        alu_a      = '0;
        alu_b      = '0;
        alu_c_in   = 1'b0;
        if (state == LO || state == HI) begin
            alu_enable = 1'b1;
            alu_sel    = (op_add || op_sub) ? ALU_ADD : op_q;
            alu_a      = (state == HI) ? a_q[WIDE_W-1:ALU_W] : a_q[ALU_W-1:0];
            alu_b      = (state == HI) ? b_q[WIDE_W-1:ALU_W] : b_q[ALU_W-1:0];
            if (op_sub) begin
                alu_b = ~alu_b;
            end
            if (state == LO) begin
                alu_c_in = op_add ? cin_q : (op_sub ? ~cin_q : 1'b0);
            end else begin
                alu_c_in = (op_add || op_sub) ? chain_q : 1'b0;
            end
        end
    end

    assign req_ready   = (state == IDLE);
    assign resp_valid  = (state == RESP);
    assign resp_result = result_q;
    assign resp_carry  = carry_q;
    assign resp_err    = err_q;
    // Gated with resp_valid so the cleared result after reset does not read as zero
    assign resp_zero   = resp_valid && (result_q == '0);

endmodule

// File: tb/tb_alu_wide_seq.sv
// tb/tb_alu_wide_seq.sv - scoreboard bench for alu_wide_seq with a behavioural 16-bit ALU
module tb_alu_wide_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        req_c_in;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic        resp_carry;
    logic        resp_zero;
    logic        resp_err;
    logic        alu_enable;
    logic [3:0]  alu_sel;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_c_in;
    logic [15:0] alu_out;
    logic        alu_c_out;

    alu_wide_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c_in    (req_c_in),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_carry  (resp_carry),
        .resp_zero   (resp_zero),
        .resp_err    (resp_err),
        .alu_enable  (alu_enable),
        .alu_sel     (alu_sel),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_c_in    (alu_c_in),
        .alu_out     (alu_out),
        .alu_c_out   (alu_c_out)
    );

    always #5 clk = ~clk;

    // Stand-in for the team's 16-bit combinational ALU
    always_comb begin
        logic [16:0] sum;
        sum       = 17'(alu_a) + 17'(alu_b) + 17'(alu_c_in);
        alu_out   = '0;
        alu_c_out = 1'b0;
        if (alu_enable) begin
            case (alu_sel)
                4'h0: begin alu_out = sum[15:0]; alu_c_out = sum[16]; end
                4'h1: alu_out = alu_a - alu_b - 16'(alu_c_in);
                4'h2: alu_out = alu_a | alu_b;
                4'h3: alu_out = alu_a & alu_b;
                4'h4: alu_out = alu_a ^ alu_b;
                4'h5: alu_out = ~(alu_a | alu_b);
                4'h6: alu_out = ~(alu_a & alu_b);
                4'h7: alu_out = ~(alu_a ^ alu_b);
                4'h8: alu_out = alu_a << 1;
                4'h9: alu_out = alu_a >> 1;
                4'hC: alu_out = ~alu_b;
                default: alu_out = 16'hDEAD;
            endcase
        end
    end

    typedef struct {
        logic [31:0] result;
        logic        carry;
        logic        zero;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   bp_mode  = 0;

    // 32-bit reference computed directly from the operation definitions
    function automatic exp_t ref_model(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b, input logic cin);
        exp_t        e;
        logic [32:0] wide;
        e.carry = 1'b0;
        e.err   = 1'b0;
        case (op)
            4'h0: begin wide = 33'(a) + 33'(b) + 33'(cin); e.result = wide[31:0]; e.carry = wide[32]; end
            4'h1: begin e.result = a - b - 32'(cin); e.carry = (33'(a) < 33'(b) + 33'(cin)); end
            4'h2: e.result = a | b;
            4'h3: e.result = a & b;
            4'h4: e.result = a ^ b;
            4'h5: e.result = ~(a | b);
            4'h6: e.result = ~(a & b);
            4'h7: e.result = ~(a ^ b);
            4'hC: e.result = ~b;
            default: begin e.result = '0; e.err = 1'b1; end
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur within bound", name);
    endtask

    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       resp_ready = 1'b1;
            1:       resp_ready = 1'($urandom_range(0, 1));
            default: resp_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL sb_unexpected: got response 0x%08h expected none", resp_result);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_result", resp_result, mon_e.result);
                check("sb_carry", 32'(resp_carry), 32'(mon_e.carry));
                check("sb_zero", 32'(resp_zero), 32'(mon_e.zero));
                check("sb_err", 32'(resp_err), 32'(mon_e.err));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
        int guard = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_c_in  = cin;
        while (!req_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            fail("send_timeout");
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb_q.push_back(ref_model(op, a, b, cin));
        #1;
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while ((sb_q.size() != 0 || !req_ready) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0 || !req_ready) fail("drain_timeout");
    endtask

    initial begin
        logic [31:0] h_res;
        logic        h_car;
        logic        h_zer;
        logic        h_err;
        logic        stray;

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_c_in   = 1'b0;
        resp_ready = 1'b0;
        #1;
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_result", resp_result, 0);
        check("rst_zero", 32'(resp_zero), 0);
        check("rst_alu_enable", 32'(alu_enable), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ADD with carry across the word boundary, plus latency
        send(4'h0, 32'h0000FFFF, 32'h00000001, 1'b0);
        @(negedge clk);
        check("add_lat_lo", 32'(resp_valid), 0);
        @(negedge clk);
        check("add_lat_hi", 32'(resp_valid), 0);
        @(negedge clk);
        check("add_lat_resp", 32'(resp_valid), 1);
        wait_idle();

        send(4'h0, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        send(4'h1, 32'h00010000, 32'h00000001, 1'b0);
        wait_idle();

        // SUB must be issued as ADD with inverted b and inverted borrow
        send(4'h1, 32'h00000000, 32'h00000001, 1'b1);
        @(negedge clk);
        check("sub_lo_enable", 32'(alu_enable), 1);
        check("sub_lo_sel", 32'(alu_sel), 0);
        check("sub_lo_b", 32'(alu_b), 32'h0000FFFE);
        check("sub_lo_cin", 32'(alu_c_in), 0);
        wait_idle();

        // Backpressure: response must hold
        bp_mode = 2;
        send(4'h4, 32'h12345678, 32'hFFFF0000, 1'b0);
        begin
            int guard = 0;
            while (!resp_valid && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        check("hold_valid", 32'(resp_valid), 1);
        h_res = resp_result;
        h_car = resp_carry;
        h_zer = resp_zero;
        h_err = resp_err;
        check("xor_direct", h_res, 32'hEDCB5678);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_result", resp_result, h_res);
            check("hold_flags", {29'd0, resp_carry, resp_zero, resp_err}, {29'd0, h_car, h_zer, h_err});
            check("hold_req_ready", 32'(req_ready), 0);
            check("hold_resp_valid", 32'(resp_valid), 1);
        end
        bp_mode = 0;
        wait_idle();

        // Unsupported op: single-cycle path, ALU untouched
        send(4'h8, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
        @(negedge clk);
        check("unsup_lat", 32'(resp_valid), 1);
        check("unsup_alu_enable", 32'(alu_enable), 0);
        wait_idle();

        // Reset during HI discards the operation
        send(4'h0, 32'h11111111, 32'h22222222, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_in_hi", 32'(alu_enable), 1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check("rst_mid_valid", 32'(resp_valid), 0);
        check("rst_mid_alu", {alu_enable, alu_sel, alu_a, alu_b, alu_c_in}, 0);
        check("rst_mid_resp", {resp_result[27:0], resp_carry, resp_zero, resp_err}, 0);
        check("rst_mid_ready", 32'(req_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (5) begin
            @(negedge clk);
            stray = stray | resp_valid;
        end
        check("rst_mid_no_resp", 32'(stray), 0);
        send(4'h0, 32'h00000005, 32'h00000007, 1'b1);
        wait_idle();

        // Randomized mix over all op codes with random backpressure
        bp_mode = 1;
        for (int i = 0; i < 60; i++) begin
            send(4'($urandom), $urandom, $urandom, 1'($urandom));
        end
        wait_idle();
        bp_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
